// File: rtl/beam_mux_arb.sv
// Packet-level round-robin arbiter feeding beam_mux.
// Holds dac_sel for a whole packet and truncates runaway packets.
module beam_mux_arb #(
  parameter int N_REQ     = 3,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 2,
  parameter int MAX_BEATS = 65536
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*DATA_W-1:0]   req_t_data,
  input  logic [N_REQ-1:0]          req_t_valid,
  input  logic [N_REQ-1:0]          req_t_last,
  output logic [N_REQ-1:0]          req_t_ready,
  input  logic [N_REQ*SEL_W-1:0]    req_dac,
  output logic [DATA_W-1:0]         mod_t_data,
  output logic                      mod_t_valid,
  input  logic                      mod_t_ready,
  output logic                      mod_t_last,
  output logic [SEL_W-1:0]          dac_sel,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      pkt_trunc
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   ptr;
  logic [GW-1:0]   winner;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            src_last;
  logic            src_valid;
  logic            force_last;
  logic            accept;

  assign src_last   = req_t_last[grant_id];
  assign src_valid  = req_t_valid[grant_id];
  assign force_last = (cnt == CW'(MAX_BEATS - 1));
  assign accept     = mod_t_valid & mod_t_ready;
  assign busy       = (state != IDLE);

  // First valid source after the last winner, with wrap.
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req_t_valid[GW'(idx)]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    mod_t_data  = '0;
    mod_t_valid = 1'b0;
    mod_t_last  = 1'b0;
    req_t_ready = '0;
    unique case (state)
      IDLE: begin
        if (found) state_nx = SETUP;
      end
      SETUP: begin
        state_nx = XFER;
      end
      XFER: begin
        mod_t_data  = req_t_data[int'(grant_id)*DATA_W +: DATA_W];
        mod_t_valid = src_valid;
        mod_t_last  = src_last | force_last;
        req_t_ready[grant_id] = mod_t_ready;
        if (src_valid && mod_t_ready && (src_last || force_last))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dac_sel   <= '0;
      grant_id  <= '0;
      ptr       <= GW'(N_REQ - 1);
      cnt       <= '0;
      pkt_done  <= 1'b0;
      pkt_trunc <= 1'b0;
    end else begin
      pkt_done  <= accept & mod_t_last;
      pkt_trunc <= accept & mod_t_last & ~src_last;
      if (state == IDLE && found) begin
        grant_id <= winner;
        ptr      <= winner;
        dac_sel  <= req_dac[int'(winner)*SEL_W +: SEL_W];
        cnt      <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/beam_mux_arb.md
Name: beam_mux_arb

Overview:
- Packet-level arbiter in front of beam_mux. It shares the single mod_t AXI-stream input and the dac_sel control between N_REQ upstream sources.
- Each source requests a whole packet and names its target DAC. The arbiter grants round-robin, drives dac_sel for that packet and passes beats through.
- dac_sel never changes inside a packet.
- Runaway packets are truncated by a beat limit.

Parameters:
- N_REQ, 3, number of requesting sources (2..8).
- DATA_W, 32, stream data width; matches beam_mux mod_t_data.
- SEL_W, 2, dac_sel width; matches beam_mux.
- MAX_BEATS, 65536, maximum beats per granted packet before forced last.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- req_t_data  in  N_REQ*DATA_W  packed source data; source i occupies bits [i*DATA_W +: DATA_W].
- req_t_valid  in  N_REQ  per-source valid.
- req_t_last  in  N_REQ  per-source end of packet.
- req_t_ready  out  N_REQ  per-source ready.
- req_dac  in  N_REQ*SEL_W  per-source target dac_sel code; sampled only at grant.
- mod_t_data  out  DATA_W  to beam_mux mod_t_data.
- mod_t_valid  out  1  to beam_mux mod_t_valid.
- mod_t_ready  in  1  from beam_mux mod_t_ready.
- mod_t_last  out  1  to beam_mux mod_t_last.
- dac_sel  out  SEL_W  to beam_mux dac_sel; registered.
- grant_id  out  clog2(N_REQ)  index of current or last granted source.
- busy  out  1  high in SETUP and XFER.
- pkt_done  out  1  one-cycle pulse on the cycle after a packet's final beat is accepted.
- pkt_trunc  out  1  one-cycle pulse, coincident with pkt_done, when that packet was cut by MAX_BEATS.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - dac_sel=0, grant_id=0, busy=0, pkt_done=0, pkt_trunc=0, beat counter=0.
  - RR pointer = N_REQ-1, so source 0 has first priority.
  - All req_t_ready=0; mod_t_valid=0, mod_t_last=0, mod_t_data=0.
  - Reset mid-packet abandons the packet with no pkt_done; the source's remaining beats form a new request after reset.
- States:
  - IDLE → SETUP: taken when any req_t_valid=1. The winner is the first valid source scanning from RR pointer+1 upward with wrap.
    - Register grant_id = winner.
    - Register dac_sel = req_dac[winner].
    - RR pointer = winner.
    - Clear the beat counter.
  - SETUP → XFER: unconditional after one cycle. All ready low and mod_t_valid=0. dac_sel is therefore stable for ≥1 cycle before the first beat.
  - XFER: combinational pass-through for granted source g.
    - mod_t_data = req data g; mod_t_valid = req_t_valid[g].
    - mod_t_last = req_t_last[g] OR (beat counter = MAX_BEATS-1).
    - req_t_ready[g] = mod_t_ready; every other req_t_ready=0.
    - A beat is accepted when mod_t_valid & mod_t_ready; each accepted beat increments the counter.
    - Accepted beat with mod_t_last=1 → IDLE. Next cycle: pkt_done=1, plus pkt_trunc=1 if req_t_last[g] was 0 on that beat.
  - In IDLE and SETUP, mod_t_data=0, mod_t_valid=0, mod_t_last=0.
- Latency and throughput:
  - Zero-cycle data path in XFER.
  - Back-to-back packets have a minimum 2-cycle bubble: the IDLE cycle plus the SETUP cycle.
- Invariants:
  - dac_sel and grant_id change only on the IDLE→SETUP transition.
  - Exactly one source may be ready at a time.
- Boundary conditions:
  - Source drops valid mid-packet: hold the grant and wait indefinitely; no timeout.
  - Single-beat packet (last on first beat): legal; counter 0→IDLE.
  - Truncation: the remainder of the truncated source is re-arbitrated as a new packet, and its req_dac is re-sampled.
  - Simultaneous valid on all sources: strict RR order, with no starvation beyond N_REQ-1 packets.
  - The RR pointer updates only at grant; a lone requester is re-granted every packet.
  - req_dac=0 is passed through as-is (beam_mux round-robin mode).

Test Plan:
- Single source 0, req_dac=01, 1024-beat packet (0..1023), mod_t_ready always 1 → dac_sel=01 one cycle before beat 0; 1024 beats out in order; mod_t_last only on beat 1023; pkt_done pulse once; pkt_trunc=0.
- Sources 0/1/2 all valid with req_dac=01/10/11, 4-beat packets each, repeated twice → grant order 0,1,2,0,1,2; dac_sel sequence 01,10,11,01,10,11; 2-cycle gap between packets.
- MAX_BEATS=8; source 1 sends a 12-beat packet → first grant emits 8 beats with forced mod_t_last, pkt_trunc=1; re-grant emits 4 beats, pkt_trunc=0.
- mod_t_ready toggling 1,0,1,0 during a 16-beat packet, with source valid gaps → every beat delivered exactly once, in order; dac_sel constant throughout; non-granted ready=0.
- Assert rst=0 for 1 cycle at beat 500 of a 1024-beat packet → next cycle all outputs at reset values, no pkt_done; next grant goes to source 0 with its req_dac re-sampled.
- Only source 2 valid, three 1-beat packets → three grants to source 2; pkt_done every 3 cycles.
